branch_commit_queue: RTL and testbench
======================================

// Module: branch_commit_queue
// PURPOSE
//   In-order queue of in-flight branches between IF and the 2-bit predictor table.
//   IF allocates one entry per predicted branch, and the ALU resolves entries out of order by tag.
//   Entries retire from the head in program order. Each retirement drives the predictor
//   update triple (commit_pc_valid, commit_pc, really_jump); a wrong prediction also
//   raises a flush with the correct redirect PC.
// PARAMETERS
//   QUEUE_DEPTH   8   number of entries; power of two, >= 2
//   TAG_WIDTH     3   log2(QUEUE_DEPTH); width of entry tags
// PORTS
//   clk             in   1   clock, all state updates on posedge
//   rst             in   1   synchronous active-high reset
//   rdy             in   1   global ready; when 0, all state frozen
//   alloc_valid     in   1   IF requests an entry this cycle
//   alloc_pc        in   32  branch instruction PC
//   alloc_pred_jump in   1   predictor's taken bit at fetch
//   alloc_pred_tgt  in   32  PC fetched next (target if taken, else pc+4)
//   alloc_ready     out  1   queue not full (count < QUEUE_DEPTH)
//   alloc_tag       out  TAG_WIDTH  tag assigned to the accepted entry (= tail ptr)
//   res_valid       in   1   ALU resolution strobe
//   res_tag         in   TAG_WIDTH  entry being resolved
//   res_jump        in   1   actual branch outcome
//   res_target      in   32  actual taken target (ignored if res_jump=0)
//   commit_pc_valid out  1   one-cycle pulse: predictor update
//   commit_pc       out  32  PC of retired branch
//   really_jump     out  1   actual outcome of retired branch
//   mispredict      out  1   one-cycle pulse: flush pipeline
//   redirect_pc     out  32  correct next PC, valid with mispredict
// BEHAVIOUR
//   - Reset: head=tail=count=0; all entry valid/resolved bits 0; every output reg 0.
//     alloc_ready=1 and alloc_tag=0 after reset.
//   - Alloc: accepted when alloc_valid & alloc_ready & rdy & !mispredict.
//     The entry is written at tail with resolved=0; tail increments mod QUEUE_DEPTH.
//   - Resolve: when res_valid & rdy and entry[res_tag] is valid, latch jump/target and set resolved=1.
//     Resolution of an invalid or already-resolved tag is ignored.
//   - Retire: at most one per cycle, when head entry valid & resolved.
//     On that edge: commit_pc_valid<=1, commit_pc<=entry.pc, really_jump<=entry.jump.
//     Head increments and the entry is invalidated.
//   - Latency: resolution written at edge N lets the head retire at edge N+1. Outputs are seen
//     after N+1. There is no same-cycle bypass from res_* to the commit outputs.
//   - Actual next PC = jump ? target : pc+4 (32-bit wrap).
//     Mispredict if actual next PC != pred_tgt.
//   - On mispredict retire, the same edge also:
//     - sets mispredict<=1 and redirect_pc<=actual next PC;
//     - clears all entries, head=tail=count=0;
//     - drops that cycle's alloc and resolve.
//     The predictor update for the mispredicted branch is still issued.
//   - Pulses (commit_pc_valid, mispredict) are high for exactly one cycle, else 0.
//     commit_pc, really_jump and redirect_pc hold their last value.
//   - Simultaneous alloc and retire: count unchanged.
//     alloc_ready is computed from the registered count only, so it stays 0 when full
//     even if a retire happens that cycle.
//   - Pointer wrap: head and tail wrap DEPTH-1 -> 0. Full and empty are distinguished by count.
//   - rdy=0: no alloc, resolve or retire; pulses driven 0; all registers hold.
//   - rst asserted mid-operation: all in-flight entries are discarded and no update is emitted.
// CONFIGURATION
//   BRANCH_STATS_EN defined:
//     - adds outputs stat_commits[31:0] and stat_mispredicts[31:0];
//     - both counters are cleared on rst and increment (wrapping) on each retire / mispredict retire.
//   BRANCH_STATS_EN undefined: those ports and counters do not exist.
//     All other behaviour is identical.
// TESTING
//   1. Reset, then alloc pc=0x100, pred_jump=0, tgt=0x104 (tag 0); resolve tag0 jump=0.
//      -> Next cycle commit_pc_valid=1, commit_pc=0x100, really_jump=0, mispredict=0.
//   2. Alloc A/B/C (tags 0,1,2), then resolve 2, 1, 0 on successive cycles.
//      -> Retires A, B, C in order on 3 consecutive cycles after tag0 resolves.
//   3. Alloc pc=0x200 with pred_tgt=0x204; resolve jump=1, target=0x300.
//      -> Next cycle mispredict=1, redirect_pc=0x300, really_jump=1; queue empty; alloc_ready=1.
//   4. Alloc 8 entries -> alloc_ready=0, and a 9th alloc is ignored. Resolve/retire one
//      -> alloc_ready=1 next cycle. The next alloc gets tag 0 (wrap).
//   5. Hold rdy=0 for 3 cycles with head resolved.
//      -> No pulses, state held; retire occurs on the first cycle rdy=1.
//   6. Assert rst with 4 entries pending.
//      -> Next cycle count=0, no commit_pc_valid pulse ever for those entries;
//         with BRANCH_STATS_EN the stats read 0.

Source files
------------

// File: rtl/branch_commit_queue.sv
// branch_commit_queue: in-order queue of in-flight branches between fetch and the
// 2-bit predictor table. Entries are allocated at the tail, resolved out of order by
// tag, and retired from the head in program order, driving the predictor update and
// a flush/redirect on a wrong prediction.
// Optional feature macro: BRANCH_STATS_EN adds retire and mispredict counters.
module branch_commit_queue #(
   parameter int unsigned QUEUE_DEPTH = 8,
   parameter int unsigned TAG_WIDTH   = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 alloc_valid,
   input  logic [31:0]          alloc_pc,
   input  logic                 alloc_pred_jump,
   input  logic [31:0]          alloc_pred_tgt,
   output logic                 alloc_ready,
   output logic [TAG_WIDTH-1:0] alloc_tag,
   input  logic                 res_valid,
   input  logic [TAG_WIDTH-1:0] res_tag,
   input  logic                 res_jump,
   input  logic [31:0]          res_target,
   output logic                 commit_pc_valid,
   output logic [31:0]          commit_pc,
   output logic                 really_jump,
   output logic                 mispredict,
   output logic [31:0]          redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]          stat_commits,
   output logic [31:0]          stat_mispredicts
`endif
);

   localparam int unsigned CNT_W = TAG_WIDTH + 1;

   logic [TAG_WIDTH-1:0]   head;
   logic [TAG_WIDTH-1:0]   tail;
   logic [CNT_W-1:0]       count;
   logic [QUEUE_DEPTH-1:0] ent_valid;
   logic [QUEUE_DEPTH-1:0] ent_resolved;
   logic [31:0]            ent_pc       [QUEUE_DEPTH];
   logic [31:0]            ent_pred_tgt [QUEUE_DEPTH];
   logic [31:0]            ent_target   [QUEUE_DEPTH];
   logic                   ent_jump     [QUEUE_DEPTH];

   logic        do_alloc;
   logic        do_resolve;
   logic        do_retire;
   logic        do_flush;
   logic [31:0] actual_npc;

   // The fetch-time taken bit is implied by the predicted target, so it is not stored.
   logic unused_pred_jump;
   assign unused_pred_jump = alloc_pred_jump;

   // Readiness depends only on the registered occupancy.
   assign alloc_ready = (count < CNT_W'(QUEUE_DEPTH));
   assign alloc_tag   = tail;

   // Per-cycle decisions: retire/flush from the head, then gated alloc and resolve.
   always_comb begin
      do_retire  = rdy && ent_valid[head] && ent_resolved[head];
      actual_npc = ent_jump[head] ? ent_target[head] : (ent_pc[head] + 32'd4);
      do_flush   = do_retire && (actual_npc != ent_pred_tgt[head]);
      do_alloc   = alloc_valid && alloc_ready && rdy && !mispredict && !do_flush;
      do_resolve = res_valid && rdy && ent_valid[res_tag] && !ent_resolved[res_tag]
                   && !do_flush;
   end

   // Entry payload storage; qualified by the valid/resolved bits, so no reset needed.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         ent_pc[tail]       <= alloc_pc;
         ent_pred_tgt[tail] <= alloc_pred_tgt;
      end
      if (do_resolve) begin
         ent_jump[res_tag]   <= res_jump;
         ent_target[res_tag] <= res_target;
      end
   end

   // Queue pointers, entry status bits and registered commit/flush outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         ent_valid        <= '0;
         ent_resolved     <= '0;
         commit_pc_valid  <= 1'b0;
         commit_pc        <= '0;
         really_jump      <= 1'b0;
         mispredict       <= 1'b0;
         redirect_pc      <= '0;
`ifdef BRANCH_STATS_EN
         stat_commits     <= '0;
         stat_mispredicts <= '0;
`endif
      end else begin
         commit_pc_valid <= 1'b0;
         mispredict      <= 1'b0;
         if (do_retire) begin
            commit_pc_valid <= 1'b1;
            commit_pc       <= ent_pc[head];
            really_jump     <= ent_jump[head];
`ifdef BRANCH_STATS_EN
            stat_commits    <= stat_commits + 32'd1;
`endif
         end
         if (do_flush) begin
            mispredict       <= 1'b1;
            redirect_pc      <= actual_npc;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            ent_valid        <= '0;
            ent_resolved     <= '0;
`ifdef BRANCH_STATS_EN
            stat_mispredicts <= stat_mispredicts + 32'd1;
`endif
         end else begin
            if (do_alloc) begin
               ent_valid[tail]    <= 1'b1;
               ent_resolved[tail] <= 1'b0;
               tail               <= tail + TAG_WIDTH'(1);
            end
            if (do_resolve) begin
               ent_resolved[res_tag] <= 1'b1;
            end
            if (do_retire) begin
               ent_valid[head]    <= 1'b0;
               ent_resolved[head] <= 1'b0;
               head               <= head + TAG_WIDTH'(1);
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_retire);
         end
      end
   end

endmodule

// File: tb/tb_branch_commit_queue.sv
// Directed bench for branch_commit_queue: a table of per-cycle vectors with
// hand-computed expected outputs, plus hand-written reset and flush sequences.
module tb_branch_commit_queue;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        alloc_valid;
   logic [31:0] alloc_pc;
   logic        alloc_pred_jump;
   logic [31:0] alloc_pred_tgt;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        res_valid;
   logic [2:0]  res_tag;
   logic        res_jump;
   logic [31:0] res_target;
   logic        commit_pc_valid;
   logic [31:0] commit_pc;
   logic        really_jump;
   logic        mispredict;
   logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_commits;
   logic [31:0] stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   branch_commit_queue #(.QUEUE_DEPTH(8), .TAG_WIDTH(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .alloc_valid     (alloc_valid),
      .alloc_pc        (alloc_pc),
      .alloc_pred_jump (alloc_pred_jump),
      .alloc_pred_tgt  (alloc_pred_tgt),
      .alloc_ready     (alloc_ready),
      .alloc_tag       (alloc_tag),
      .res_valid       (res_valid),
      .res_tag         (res_tag),
      .res_jump        (res_jump),
      .res_target      (res_target),
      .commit_pc_valid (commit_pc_valid),
      .commit_pc       (commit_pc),
      .really_jump     (really_jump),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc)
`ifdef BRANCH_STATS_EN
      ,
      .stat_commits    (stat_commits),
      .stat_mispredicts(stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic        av;
      logic [31:0] apc;
      logic        apj;
      logic [31:0] atgt;
      logic        rv;
      logic [2:0]  rtag;
      logic        rj;
      logic [31:0] rtgt;
      logic        e_ar;
      logic [2:0]  e_tag;
      logic        e_cpv;
      logic [31:0] e_cpc;
      logic        e_rj;
      logic        e_mp;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rd, input logic av, input logic [31:0] apc,
                               input logic apj, input logic [31:0] atgt, input logic rv,
                               input logic [2:0] rtag, input logic rj, input logic [31:0] rtgt,
                               input logic ar, input logic [2:0] tag, input logic cpv,
                               input logic [31:0] cpc, input logic crj, input logic mp,
                               input logic [31:0] rpc);
      vec_t v;
      v.rdy = rd;   v.av = av;     v.apc = apc;   v.apj = apj;   v.atgt = atgt;
      v.rv = rv;    v.rtag = rtag; v.rj = rj;     v.rtgt = rtgt;
      v.e_ar = ar;  v.e_tag = tag; v.e_cpv = cpv; v.e_cpc = cpc; v.e_rj = crj;
      v.e_mp = mp;  v.e_rpc = rpc;
      return v;
   endfunction

   function automatic vec_t idle(input logic ar, input logic [2:0] tag, input logic cpv,
                                 input logic [31:0] cpc, input logic crj, input logic mp,
                                 input logic [31:0] rpc);
      return mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0,
                ar, tag, cpv, cpc, crj, mp, rpc);
   endfunction

   function automatic vec_t al(input logic [31:0] apc, input logic apj, input logic [31:0] atgt,
                               input logic ar, input logic [2:0] tag, input logic cpv,
                               input logic [31:0] cpc, input logic crj, input logic mp,
                               input logic [31:0] rpc);
      return mk(1'b1, 1'b1, apc, apj, atgt, 1'b0, 3'd0, 1'b0, 32'h0,
                ar, tag, cpv, cpc, crj, mp, rpc);
   endfunction

   function automatic vec_t rs(input logic [2:0] rtag, input logic rj, input logic [31:0] rtgt,
                               input logic ar, input logic [2:0] tag, input logic cpv,
                               input logic [31:0] cpc, input logic crj, input logic mp,
                               input logic [31:0] rpc);
      return mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rtag, rj, rtgt,
                ar, tag, cpv, cpc, crj, mp, rpc);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic ar, input logic [2:0] tag,
                           input logic cpv, input logic [31:0] cpc, input logic crj,
                           input logic mp, input logic [31:0] rpc);
      chk({nm, ".alloc_ready"},     32'(alloc_ready),     32'(ar));
      chk({nm, ".alloc_tag"},       32'(alloc_tag),       32'(tag));
      chk({nm, ".commit_pc_valid"}, 32'(commit_pc_valid), 32'(cpv));
      chk({nm, ".commit_pc"},       commit_pc,            cpc);
      chk({nm, ".really_jump"},     32'(really_jump),     32'(crj));
      chk({nm, ".mispredict"},      32'(mispredict),      32'(mp));
      chk({nm, ".redirect_pc"},     redirect_pc,          rpc);
   endtask

   // Drive inputs on the falling edge, then sample just after the next rising edge.
   task automatic drive(input logic r, input logic rd, input logic av, input logic [31:0] apc,
                        input logic apj, input logic [31:0] atgt, input logic rv,
                        input logic [2:0] rtag, input logic rj, input logic [31:0] rtgt);
      @(negedge clk);
      rst = r; rdy = rd; alloc_valid = av; alloc_pc = apc; alloc_pred_jump = apj;
      alloc_pred_tgt = atgt; res_valid = rv; res_tag = rtag; res_jump = rj; res_target = rtgt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic r);
      drive(r, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_pc = '0; alloc_pred_jump = 1'b0;
      alloc_pred_tgt = '0; res_valid = 1'b0; res_tag = '0; res_jump = 1'b0; res_target = '0;

      // Single predicted-not-taken branch, correct.
      vq.push_back(al(32'h100, 1'b0, 32'h104, 1, 3'd1, 0, 32'h0,   0, 0, 32'h0));
      vq.push_back(rs(3'd0, 1'b0, 32'h0,      1, 3'd1, 0, 32'h0,   0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd1, 1, 32'h100, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd1, 0, 32'h100, 0, 0, 32'h0));
      // Out-of-order resolution, in-order retirement.
      vq.push_back(al(32'h110, 1'b0, 32'h114, 1, 3'd2, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(al(32'h120, 1'b0, 32'h124, 1, 3'd3, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(al(32'h130, 1'b0, 32'h134, 1, 3'd4, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(rs(3'd3, 1'b0, 32'h0,      1, 3'd4, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(rs(3'd2, 1'b0, 32'h0,      1, 3'd4, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(rs(3'd1, 1'b0, 32'h0,      1, 3'd4, 0, 32'h100, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd4, 1, 32'h110, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd4, 1, 32'h120, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd4, 1, 32'h130, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd4, 0, 32'h130, 0, 0, 32'h0));
      // Predicted not-taken, actually taken: flush to the real target.
      vq.push_back(al(32'h200, 1'b0, 32'h204, 1, 3'd5, 0, 32'h130, 0, 0, 32'h0));
      vq.push_back(rs(3'd4, 1'b1, 32'h300,    1, 3'd5, 0, 32'h130, 0, 0, 32'h0));
      vq.push_back(idle(                      1, 3'd0, 1, 32'h200, 1, 1, 32'h300));
      vq.push_back(idle(                      1, 3'd0, 0, 32'h200, 1, 0, 32'h300));
      // Fill all eight entries with predicted-taken branches.
      for (int i = 0; i < 8; i++)
         vq.push_back(al(32'h400 + 32'(16 * i), 1'b1, 32'h800 + 32'(16 * i),
                         (i < 7), 3'((i + 1) % 8), 0, 32'h200, 1, 0, 32'h300));
      vq.push_back(al(32'h999, 1'b0, 32'h99d, 0, 3'd0, 0, 32'h200, 1, 0, 32'h300));
      vq.push_back(rs(3'd0, 1'b1, 32'h800,    0, 3'd0, 0, 32'h200, 1, 0, 32'h300));
      // Retire while full: the same-cycle alloc is still refused.
      vq.push_back(al(32'h990, 1'b0, 32'h994, 1, 3'd0, 1, 32'h400, 1, 0, 32'h300));
      vq.push_back(al(32'h480, 1'b0, 32'h484, 0, 3'd1, 0, 32'h400, 1, 0, 32'h300));
      // Head resolved, then rdy low for three cycles.
      vq.push_back(rs(3'd1, 1'b1, 32'h810,    0, 3'd1, 0, 32'h400, 1, 0, 32'h300));
      for (int i = 0; i < 3; i++)
         vq.push_back(mk(1'b0, 1'b1, 32'h9a0, 1'b0, 32'h9a4, 1'b1, 3'd3, 1'b1, 32'h830,
                         0, 3'd1, 0, 32'h400, 1, 0, 32'h300));
      vq.push_back(idle(                      1, 3'd1, 1, 32'h410, 1, 0, 32'h300));
      vq.push_back(rs(3'd2, 1'b1, 32'h820,    1, 3'd1, 0, 32'h410, 1, 0, 32'h300));

      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", 1, 3'd0, 0, 32'h0, 0, 0, 32'h0);
`ifdef BRANCH_STATS_EN
      chk("reset.stat_commits", stat_commits, 32'd0);
      chk("reset.stat_mispredicts", stat_mispredicts, 32'd0);
`endif

      foreach (vq[k]) begin
         drive(1'b0, vq[k].rdy, vq[k].av, vq[k].apc, vq[k].apj, vq[k].atgt,
               vq[k].rv, vq[k].rtag, vq[k].rj, vq[k].rtgt);
         chk_outs($sformatf("vec%0d", k), vq[k].e_ar, vq[k].e_tag, vq[k].e_cpv,
                  vq[k].e_cpc, vq[k].e_rj, vq[k].e_mp, vq[k].e_rpc);
      end
`ifdef BRANCH_STATS_EN
      chk("pre_rst.stat_commits", stat_commits, 32'd7);
      chk("pre_rst.stat_mispredicts", stat_mispredicts, 32'd1);
`endif

      // Reset on the edge where the resolved head would otherwise retire.
      idle_cycle(1'b1);
      chk_outs("midrst", 1, 3'd0, 0, 32'h0, 0, 0, 32'h0);
`ifdef BRANCH_STATS_EN
      chk("midrst.stat_commits", stat_commits, 32'd0);
      chk("midrst.stat_mispredicts", stat_mispredicts, 32'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         idle_cycle(1'b0);
         chk($sformatf("midrst_quiet%0d.commit_pc_valid", i), 32'(commit_pc_valid), 32'd0);
         chk($sformatf("midrst_quiet%0d.alloc_tag", i), 32'(alloc_tag), 32'd0);
      end

      // Predicted taken, actually not taken: redirect to pc+4, same-cycle alloc/resolve dropped.
      drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 3'd0, 1'b0, 32'h0);
      chk_outs("flush_a0", 1, 3'd1, 0, 32'h0, 0, 0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h510, 1'b0, 32'h514, 1'b0, 3'd0, 1'b0, 32'h0);
      chk_outs("flush_a1", 1, 3'd2, 0, 32'h0, 0, 0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b0, 32'h0);
      chk_outs("flush_r0", 1, 3'd2, 0, 32'h0, 0, 0, 32'h0);
      drive(1'b0, 1'b1, 1'b1, 32'h520, 1'b0, 32'h524, 1'b1, 3'd1, 1'b0, 32'h0);
      chk_outs("flush_edge", 1, 3'd0, 1, 32'h500, 0, 1, 32'h504);
      for (int i = 0; i < 2; i++) begin
         idle_cycle(1'b0);
         chk_outs($sformatf("flush_after%0d", i), 1, 3'd0, 0, 32'h500, 0, 0, 32'h504);
      end
`ifdef BRANCH_STATS_EN
      chk("flush.stat_commits", stat_commits, 32'd1);
      chk("flush.stat_mispredicts", stat_mispredicts, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
